// File: rtl/fir_pkg.sv
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and defaults for the FIR MAC sequencer.
//                Optional flush port is enabled by FIR_FLUSH_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 39;

    function automatic int tap_idx_w(input int taps);
        return (taps <= 2) ? 1 : $clog2(taps);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_tap_bank.sv
// ============================================================================
//  Module      : fir_tap_bank
//  Description : Sample delay line and coefficient registers with tap read mux.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fir_tap_bank #(
    parameter int TAPS = 8,
    parameter int DW   = 16,
    parameter int KW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr_d,
    input  logic          i_shift,
    input  logic [DW-1:0] i_sample,
    input  logic          i_wr_en,
    input  logic [KW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [KW-1:0] i_rd_idx,
    output logic [DW-1:0] o_rd_d,
    output logic [DW-1:0] o_rd_c
);

    logic [DW-1:0] r_d [TAPS];
    logic [DW-1:0] r_c [TAPS];

    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        if (i == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d[i] <= '0;
                end else if (i_clr_d) begin
                    r_d[i] <= '0;
                end else if (i_shift) begin
                    r_d[i] <= i_sample;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d[i] <= '0;
                end else if (i_clr_d) begin
                    r_d[i] <= '0;
                end else if (i_shift) begin
                    r_d[i] <= r_d[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_c[i] <= '0;
            end else if (i_wr_en && (i_wr_addr == KW'(i))) begin
                r_c[i] <= i_wr_data;
            end
        end
    end

    assign o_rd_d = r_d[i_rd_idx];
    assign o_rd_c = r_c[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// ============================================================================
//  Module      : fir_mac_sequencer
//  Description : Steps a shared MAC through TAPS products per accepted sample
//                and returns the accumulator via a valid/ready handshake.
//                Define FIR_FLUSH_EN to add the delay-line flush input.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS = 8,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef FIR_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_sample,
    input  logic                         coef_we,
    input  logic [tap_idx_w(TAPS)-1:0]   coef_addr,
    input  logic [DW-1:0]                coef_data,
    output logic [DW-1:0]                mac_a,
    output logic [DW-1:0]                mac_b,
    output logic                         mac_en,
    output logic                         mac_clr,
    input  logic [AW-1:0]                mac_acc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [AW-1:0]                out_data
);

    localparam int KW = tap_idx_w(TAPS);
    localparam logic [KW-1:0] c_last_k   = KW'(TAPS - 1);
    localparam logic [KW:0]   c_taps_ext = (KW + 1)'(TAPS);

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic          r_idle;
    logic          r_run;
    logic          r_clr;
    logic          r_out_valid;
    logic [AW-1:0] r_out_data;

    logic          w_flush;
    logic          w_accept;
    logic          w_coef_wr;
    logic [DW-1:0] w_tap_d;
    logic [DW-1:0] w_tap_c;

`ifdef FIR_FLUSH_EN
    assign w_flush = flush & r_idle;
`else
    assign w_flush = 1'b0;
`endif

    // Flush wins over a coincident sample, so the handshake is withheld
    assign in_ready  = r_idle & ~w_flush;
    assign w_accept  = in_ready & in_valid;
    assign w_coef_wr = r_idle & coef_we & ({1'b0, coef_addr} < c_taps_ext);

    fir_tap_bank #(
        .TAPS (TAPS),
        .DW   (DW),
        .KW   (KW)
    ) u_tap_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr_d   (w_flush),
        .i_shift   (w_accept),
        .i_sample  (in_sample),
        .i_wr_en   (w_coef_wr),
        .i_wr_addr (coef_addr),
        .i_wr_data (coef_data),
        .i_rd_idx  (r_k),
        .o_rd_d    (w_tap_d),
        .o_rd_c    (w_tap_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_idle      <= 1'b1;
            r_run       <= 1'b0;
            r_clr       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_k     <= '0;
                        r_idle  <= 1'b0;
                        r_run   <= 1'b1;
                        r_clr   <= 1'b1;
                    end
                end
                RUN: begin
                    r_clr <= 1'b0;
                    if (r_k == c_last_k) begin
                        r_state <= WAIT;
                        r_run   <= 1'b0;
                        r_k     <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                // Last product lands in mac_acc during this cycle
                WAIT: begin
                    r_out_data  <= mac_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idle      <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_k         <= '0;
                    r_idle      <= 1'b1;
                    r_run       <= 1'b0;
                    r_clr       <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mac_a     = r_run ? w_tap_d : '0;
    assign mac_b     = r_run ? w_tap_c : '0;
    assign mac_en    = r_run;
    assign mac_clr   = r_clr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// ============================================================================
//  Module      : tb_fir_mac_sequencer
//  Description : Directed bench for fir_mac_sequencer with a behavioural MAC.
//                Flush vectors are included when FIR_FLUSH_EN is defined.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fir_mac_sequencer;

    localparam int TAPS = 8;
    localparam int DW   = 16;
    localparam int AW   = 39;
    localparam int KW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_sample = '0;
    logic          coef_we = 1'b0;
    logic [KW-1:0] coef_addr = '0;
    logic [DW-1:0] coef_data = '0;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic          mac_en;
    logic          mac_clr;
    logic [AW-1:0] mac_acc = 39'h12_3456_789A;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC; starts from a nonzero value so a missing clear shows up
    always @(posedge clk) begin
        if (mac_en)
            mac_acc <= (mac_clr ? '0 : mac_acc) + AW'(mac_a * mac_b);
    end

    fir_mac_sequencer #(
        .TAPS (TAPS),
        .DW   (DW),
        .AW   (AW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FIR_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_acc   (mac_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic write_coef(input logic [KW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic start_sample(input logic [DW-1:0] x);
        int n;
        n = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = x;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic finish_sample(output logic [AW-1:0] data, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
        lat  = cyc - acc_cyc + 1;
        data = out_data;
    endtask

    task automatic send(input string tag, input logic [DW-1:0] x, input logic [AW-1:0] exp,
                        input bit chk_lat);
        logic [AW-1:0] d;
        int            lat;
        start_sample(x);
        finish_sample(d, lat);
        check(tag, 64'(d), 64'(exp));
        if (chk_lat) check({tag, "_latency"}, 64'(lat), 64'(TAPS + 2));
    endtask

    logic [AW-1:0] r_data;
    int            r_lat;
    bit            stable_ok;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mac_en", 64'(mac_en), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_mac_ab", 64'({mac_a, mac_b}), 64'd0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of RUN
        for (int i = 0; i < TAPS; i++) write_coef(KW'(i), DW'(i + 1));
        start_sample(16'd9);
        repeat (3) @(negedge clk);
        check("midrun_mac_en_before", 64'(mac_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_out_valid", 64'(out_valid), 64'd0);
        check("midrun_mac_en", 64'(mac_en), 64'd0);
        check("midrun_mac_clr", 64'(mac_clr), 64'd0);
        check("midrun_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send("post_rst_zero_coef", 16'd7, 39'd0, 1'b1);

        // Clean slate for the impulse response
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < TAPS; i++) write_coef(KW'(i), DW'(i + 1));
        send("impulse_0", 16'd1, 39'd1, 1'b1);
        for (int i = 1; i < TAPS; i++)
            send($sformatf("impulse_%0d", i), 16'd0, AW'(i + 1), 1'b1);

        // Write during RUN is dropped; same write in IDLE lands
        start_sample(16'd10);
        write_coef(3'd0, 16'd5);
        finish_sample(r_data, r_lat);
        check("drop_run_write", 64'(r_data), 64'd10);
        write_coef(3'd0, 16'd5);
        send("idle_write", 16'd10, 39'd70, 1'b0);

        // Full-scale accumulation without wrap
        for (int i = 0; i < TAPS; i++) write_coef(KW'(i), 16'hFFFF);
        for (int i = 0; i < TAPS - 1; i++) begin
            start_sample(16'hFFFF);
            finish_sample(r_data, r_lat);
        end
        send("full_scale", 16'hFFFF, 39'h7_FFF0_0008, 1'b1);

        // Backpressure with a pending sample held by the source
        @(negedge clk);
        out_ready = 1'b0;
        start_sample(16'd1);
        in_valid  = 1'b1;
        in_sample = 16'd2;
        finish_sample(r_data, r_lat);
        check("bp_first", 64'(r_data), 64'h6_FFF3_0006);
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && out_data === 39'h6_FFF3_0006 &&
                  in_ready === 1'b0 && mac_en === 1'b0))
                stable_ok = 1'b0;
        end
        check("bp_hold_stable", 64'(stable_ok), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        finish_sample(r_data, r_lat);
        check("bp_pending", 64'(r_data), 64'h5_FFF7_0003);
        check("bp_pending_latency", 64'(r_lat), 64'(TAPS + 2));

`ifdef FIR_FLUSH_EN
        // Flush clears samples but keeps coefficients
        for (int i = 0; i < TAPS; i++) write_coef(KW'(i), 16'd1);
        for (int i = 0; i < TAPS; i++) begin
            start_sample(16'd3);
            finish_sample(r_data, r_lat);
        end
        check("flush_fill", 64'(r_data), 64'd24);
        @(negedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        send("flush_zero", 16'd0, 39'd0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
